// File: rtl/uart_rx_8x.sv
// uart_rx_8x
// Serial receiver for frames with one start bit, DATA_BITS data bits sent
// LSB first, no parity and one stop bit. The line is oversampled with an 8x
// tick from baud_gen. This block drives baud_gen's enable, so the tick phase
// restarts at every detected start edge.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   rx        asynchronous serial line, idle high
//   tick_8x   one-cycle pulse at 8x the baud rate (from baud_gen)
//   baud_en   enable for baud_gen, high while a frame is in progress
//   rx_data   last received word, held until the next frame completes
//   rx_valid  one-cycle pulse, frame ended with a good stop bit
//   frame_err one-cycle pulse, stop bit sampled low
//   busy      high whenever the receiver is not idle
module uart_rx_8x #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick_8x,
  output logic                 baud_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_next;

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [2:0]           tcnt;
  logic [2:0]           samp;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic fall;
  logic bit_end;
  logic stop_point;
  logic vote_full;
  logic vote_stop;
  logic last_bit;

  assign fall       = rx_prev & ~rx_sync;
  assign bit_end    = tick_8x && (tcnt == 3'd7);
  assign stop_point = tick_8x && (tcnt == 3'd4);
  assign last_bit   = (bit_idx == 4'(DATA_BITS - 1));

  // Majority of the 3rd/4th/5th tick samples once a whole bit has been seen.
  assign vote_full = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  // The stop bit is decided on its 5th tick itself, so the third sample is
  // taken straight from the synchronizer instead of the sample register.
  assign vote_stop = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

  assign baud_en = (state != IDLE);
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Ticks are ignored while idle, including one that lands
  // on the same cycle as the start-edge detect.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (fall) state_next = START;
      START: if (bit_end) state_next = vote_full ? IDLE : DATA;
      DATA:  if (bit_end && last_bit) state_next = STOP;
      STOP:  if (stop_point) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Synchronizer, edge-detect history, tick counter, bit sampling, shift
  // register and the registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      tcnt      <= 3'd0;
      samp      <= 3'd0;
      bit_idx   <= 4'd0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE) begin
        if (fall) begin
          tcnt    <= 3'd0;
          samp    <= 3'd0;
          bit_idx <= 4'd0;
        end
      end else if (tick_8x) begin
        tcnt <= tcnt + 3'd1;

        unique case (tcnt)
          3'd2:    samp[0] <= rx_sync;
          3'd3:    samp[1] <= rx_sync;
          3'd4:    samp[2] <= rx_sync;
          default: ;
        endcase

        if (state == STOP) begin
          if (tcnt == 3'd4) begin
            tcnt      <= 3'd0;
            samp      <= 3'd0;
            rx_data   <= shreg;
            rx_valid  <= vote_stop;
            frame_err <= ~vote_stop;
          end
        end else if (tcnt == 3'd7) begin
          samp <= 3'd0;
          if (state == DATA) begin
            shreg   <= {vote_full, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_8x.sv
// tb_uart_rx_8x
// Self-checking bench for uart_rx_8x. A behavioural baud_gen model supplies
// tick_8x every 108 cycles while baud_en is high. The reference model is the
// frame-level view of a UART: every frame that completes delivers the word
// that was sent, flagged as a frame error exactly when its stop bit was 0.
module tb_uart_rx_8x;

  localparam int CPB = 864;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tick_8x;
  logic       baud_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       both;
  } ev_t;

  ev_t        events[$];
  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;
  int         bcnt;

  always #5 clk = ~clk;

  uart_rx_8x #(.DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tick_8x  (tick_8x),
    .baud_en  (baud_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // baud_gen model: counter held at zero while disabled, one tick every 108
  // enabled cycles.
  always @(posedge clk) begin
    if (rst || !baud_en) begin
      bcnt    <= 0;
      tick_8x <= 1'b0;
    end else if (bcnt == 107) begin
      bcnt    <= 0;
      tick_8x <= 1'b1;
    end else begin
      bcnt    <= bcnt + 1;
      tick_8x <= 1'b0;
    end
  end

  // Every high cycle of either pulse is logged, so a stretched pulse shows up
  // as an extra event.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err))
      events.push_back('{rx_data, frame_err, rx_valid && frame_err});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; spike_pos selects a frame bit (0 = start) that gets a
  // 108-cycle pulse of spike_val centred in the bit, -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb,
                            input int spike_pos, input logic spike_val);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == spike_pos) begin
        cyc(cpb / 2 - 54);
        rx = spike_val;
        cyc(108);
        rx = bits[i];
        cyc(cpb - cpb / 2 - 54);
      end else begin
        cyc(cpb);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    checks += 5;
    if (baud_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_baud_en: got %b expected 0", baud_en); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
  endtask

  task automatic test_glitch();
    events.delete();
    rx = 1'b0;
    cyc(2);
    checks++;
    if (baud_en !== 1'b0) begin errors++; $display("[TB] FAIL glitch_latency_early: got %b expected 0", baud_en); end
    cyc(1);
    checks += 2;
    if (baud_en !== 1'b1) begin errors++; $display("[TB] FAIL glitch_latency_baud_en: got %b expected 1", baud_en); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_latency_busy: got %b expected 1", busy); end
    cyc(197);
    rx = 1'b1;
    cyc(600);
    checks++;
    if (baud_en !== 1'b1) begin errors++; $display("[TB] FAIL glitch_hold: got %b expected 1", baud_en); end
    cyc(100);
    checks += 3;
    if (baud_en !== 1'b0) begin errors++; $display("[TB] FAIL glitch_drop: got %b expected 0", baud_en); end
    if (events.size() !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", events.size()); end
    if (rx_data !== last_data) begin errors++; $display("[TB] FAIL glitch_rx_data: got %h expected %h", rx_data, last_data); end
  endtask

  task automatic test_nominal();
    events.delete();
    send_frame(8'hA5, 1'b1, CPB, -1, 1'b0);
    cyc(20);
    last_data = 8'hA5;
    checks++;
    if (events.size() !== 1) begin
      errors++; $display("[TB] FAIL nominal_count: got %0d expected 1", events.size());
    end else begin
      checks += 2;
      if (events[0].data !== 8'hA5) begin errors++; $display("[TB] FAIL nominal_data: got %h expected a5", events[0].data); end
      if (events[0].err !== 1'b0) begin errors++; $display("[TB] FAIL nominal_err: got %b expected 0", events[0].err); end
    end
    checks++;
    if (baud_en !== 1'b0) begin errors++; $display("[TB] FAIL nominal_baud_en: got %b expected 0", baud_en); end
  endtask

  task automatic test_frame_error();
    int         busy_cycles;
    logic [7:0] d;
    events.delete();
    send_frame(8'h3C, 1'b0, CPB, -1, 1'b0);
    last_data = 8'h3C;
    busy_cycles = 0;
    for (int i = 0; i < 20000; i++) begin
      cyc(1);
      if (busy) busy_cycles++;
    end
    checks += 2;
    if (busy_cycles !== 0) begin errors++; $display("[TB] FAIL break_busy_cycles: got %0d expected 0", busy_cycles); end
    if (events.size() !== 1) begin
      errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", events.size());
    end else begin
      checks += 3;
      if (events[0].data !== 8'h3C) begin errors++; $display("[TB] FAIL ferr_data: got %h expected 3c", events[0].data); end
      if (events[0].err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", events[0].err); end
      if (events[0].both !== 1'b0) begin errors++; $display("[TB] FAIL ferr_exclusive: got %b expected 0", events[0].both); end
    end
    // The line recovers and a fresh frame must be accepted.
    rx = 1'b1;
    cyc(50);
    events.delete();
    d = 8'($urandom_range(0, 255));
    send_frame(d, 1'b1, CPB, -1, 1'b0);
    cyc(20);
    last_data = d;
    checks++;
    if (events.size() !== 1 || events[0].data !== d || events[0].err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_break: got %0d pulses data %h expected 1 pulse data %h",
               events.size(), (events.size() > 0) ? events[0].data : 8'hxx, d);
    end
  endtask

  task automatic test_back_to_back();
    events.delete();
    send_frame(8'hFF, 1'b1, CPB, -1, 1'b0);
    send_frame(8'h00, 1'b1, CPB, -1, 1'b0);
    cyc(20);
    last_data = 8'h00;
    checks++;
    if (events.size() !== 2) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", events.size());
    end else begin
      checks += 4;
      if (events[0].data !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_data0: got %h expected ff", events[0].data); end
      if (events[1].data !== 8'h00) begin errors++; $display("[TB] FAIL b2b_data1: got %h expected 00", events[1].data); end
      if (events[0].err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err0: got %b expected 0", events[0].err); end
      if (events[1].err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err1: got %b expected 0", events[1].err); end
    end
  endtask

  task automatic test_noise();
    events.delete();
    // High spike on data bit 2 (a 1 bit), then on data bit 5 (a 0 bit).
    send_frame(8'h0F, 1'b1, CPB, 3, 1'b1);
    cyc(100);
    send_frame(8'h0F, 1'b1, CPB, 6, 1'b1);
    cyc(20);
    last_data = 8'h0F;
    checks++;
    if (events.size() !== 2) begin
      errors++; $display("[TB] FAIL noise_count: got %0d expected 2", events.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks += 2;
        if (events[i].data !== 8'h0F) begin errors++; $display("[TB] FAIL noise_data%0d: got %h expected 0f", i, events[i].data); end
        if (events[i].err !== 1'b0) begin errors++; $display("[TB] FAIL noise_err%0d: got %b expected 0", i, events[i].err); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    events.delete();
    d = 8'h5A;
    // Start bit and data bits 0..3, then the transmitter abandons the frame
    // part way through data bit 4 (a 1) while the receiver is reset.
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      cyc(CPB);
    end
    rx = d[4];
    cyc(400);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks += 3;
    if (baud_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_baud_en: got %b expected 0", baud_en); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    rx = 1'b1;
    cyc(2000);
    checks++;
    if (events.size() !== 0) begin errors++; $display("[TB] FAIL rstmid_pulses: got %0d expected 0", events.size()); end
    send_frame(8'hC3, 1'b1, CPB, -1, 1'b0);
    cyc(20);
    last_data = 8'hC3;
    checks++;
    if (events.size() !== 1 || events[0].data !== 8'hC3 || events[0].err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_next: got %0d pulses data %h expected 1 pulse data c3",
               events.size(), (events.size() > 0) ? events[0].data : 8'hxx);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    int         cpb;
    int         gap;
    events.delete();
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      cpb  = $urandom_range(850, 878);
      gap  = stop ? $urandom_range(0, 500) : $urandom_range(20, 500);
      send_frame(d, stop, cpb, -1, 1'b0);
      rx = 1'b1;
      cyc(gap);
      exp_q.push_back('{d, !stop, 1'b0});
      last_data = d;
    end
    cyc(20);
    checks++;
    if (events.size() !== exp_q.size()) begin
      errors++; $display("[TB] FAIL random_count: got %0d expected %0d", events.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < events.size(); i++) begin
      checks += 3;
      if (events[i].data !== exp_q[i].data) begin errors++; $display("[TB] FAIL random_data%0d: got %h expected %h", i, events[i].data, exp_q[i].data); end
      if (events[i].err !== exp_q[i].err) begin errors++; $display("[TB] FAIL random_err%0d: got %b expected %b", i, events[i].err, exp_q[i].err); end
      if (events[i].both !== 1'b0) begin errors++; $display("[TB] FAIL random_exclusive%0d: got %b expected 0", i, events[i].both); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_glitch();
    test_nominal();
    test_frame_error();
    test_back_to_back();
    test_noise();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
